// File: rtl/key_entry.sv
// Push-button conditioner: synchronises key and switches, debounces the key and
// emits one strobe (plus latched switch nibble) per accepted press or auto-repeat.
module key_entry #(
  parameter int DEBOUNCE      = 500000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic [3:0] sw,
  output logic       strobe,
  output logic [3:0] data,
  output logic       pressed
);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             keyMeta_q, keyS_q;
  logic [3:0]       swMeta_q, swS_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire;
  logic             strobe_q, strobe_d;
  logic [3:0]       data_q, data_d;
  logic             pressed_q, pressed_d;

  // Key idles released (high) out of reset so a held button cannot look like a fresh press.
  always_ff @(posedge clock) begin
    if (reset) begin
      keyMeta_q <= 1'b1;
      keyS_q    <= 1'b1;
      swMeta_q  <= '0;
      swS_q     <= '0;
    end else begin
      keyMeta_q <= key_n;
      keyS_q    <= keyMeta_q;
      swMeta_q  <= sw;
      swS_q     <= swMeta_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ARM;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      data_q    <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      strobe_q  <= strobe_d;
      data_q    <= data_d;
      pressed_q <= pressed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    fire    = 1'b0;
    unique case (state_q)
      ARM: begin
        if (!keyS_q) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        cnt_d = cnt_q;
        if (!keyS_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (keyS_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          fire    = 1'b1;
        end
      end
      HELD: begin
        if (keyS_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if ((REPEAT_EN != 0) && (cnt_q == DLY_LAST)) begin
          state_d = REPEAT;
          cnt_d   = '0;
          fire    = 1'b1;
        end else if (cnt_q == '1) begin
          cnt_d = cnt_q;
        end
      end
      REPEAT: begin
        if (keyS_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          cnt_d = '0;
          fire  = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!keyS_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARM;
        cnt_d   = '0;
      end
    endcase
  end

  // With delay/period of 1 two strobes could fall on adjacent edges; the second is dropped.
  always_comb begin
    strobe_d  = fire && !strobe_q;
    data_d    = strobe_d ? swS_q : data_q;
    pressed_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_WAIT);
  end

  assign strobe  = strobe_q;
  assign data    = data_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: directed scenarios plus random key traffic, all checked against a
// run-length reference model of the debounce and hold-time rules.
module tb_key_entry;

  localparam int D   = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic [3:0] sw    = 4'h0;
  logic       strobeA, pressedA, strobeB, pressedB;
  logic [3:0] dataA, dataB;

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;

  key_entry #(.DEBOUNCE(D), .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_W(6)) dutA (
    .clock(clock), .reset(reset), .key_n(key_n), .sw(sw),
    .strobe(strobeA), .data(dataA), .pressed(pressedA)
  );

  key_entry #(.DEBOUNCE(D), .REPEAT_EN(0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_W(6)) dutB (
    .clock(clock), .reset(reset), .key_n(key_n), .sw(sw),
    .strobe(strobeB), .data(dataB), .pressed(pressedB)
  );

  always #5 clock = ~clock;

  // Reference model: key acceptance is a run-length rule on the synchronised key, repeats are
  // arithmetic on the number of edges since the hold began. Index 0 repeats, index 1 does not.
  logic       mKeyMeta = 1'b1, mKeyS = 1'b1;
  logic [3:0] mSwMeta = 4'h0, mSwS = 4'h0;
  int         zeroRun = 0, oneRun = 0;
  bit         mArmed[2];
  bit         mPressed[2];
  int         holdK[2];
  logic       mStrobe[2];
  logic [3:0] mData[2];

  task automatic modelEdge();
    logic s;
    if (reset) begin
      mKeyMeta = 1'b1; mKeyS = 1'b1; mSwMeta = 4'h0; mSwS = 4'h0;
      zeroRun = 0; oneRun = 0;
      for (int i = 0; i < 2; i++) begin
        mArmed[i] = 0; mPressed[i] = 0; holdK[i] = -1; mStrobe[i] = 1'b0; mData[i] = 4'h0;
      end
    end else begin
      s = mKeyS;
      if (s) begin oneRun++; zeroRun = 0; end
      else begin zeroRun++; oneRun = 0; end
      for (int i = 0; i < 2; i++) begin
        mStrobe[i] = 1'b0;
        if (!mArmed[i]) begin
          if (s && oneRun == D) mArmed[i] = 1;
        end else if (!mPressed[i]) begin
          if (!s && zeroRun == D + 1) begin
            mPressed[i] = 1; holdK[i] = 0; mStrobe[i] = 1'b1;
          end
        end else if (s) begin
          holdK[i] = -1;
          if (oneRun == D + 1) mPressed[i] = 0;
        end else if (holdK[i] < 0) begin
          holdK[i] = 0;
        end else begin
          holdK[i]++;
          if (i == 0 && (holdK[i] == DLY || (holdK[i] > DLY && (holdK[i] - DLY) % PER == 0)))
            mStrobe[i] = 1'b1;
        end
        if (mStrobe[i]) mData[i] = mSwS;
      end
      mKeyS = mKeyMeta; mKeyMeta = key_n;
      mSwS = mSwMeta; mSwMeta = sw;
    end
  endtask

  function automatic logic [11:0] expVec();
    return {mStrobe[0], mData[0], mPressed[0], mStrobe[1], mData[1], mPressed[1]};
  endfunction

  function automatic logic [11:0] obsVec();
    return {strobeA, dataA, pressedA, strobeB, dataB, pressedB};
  endfunction

  task automatic tick();
    @(posedge clock);
    modelEdge();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_n = 1'b1; sw = 4'hA;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if ({strobeA, dataA, pressedA, strobeB, dataB, pressedB} !== 12'h000) begin
        failCount++;
        $display("[TB] FAIL reset_outputs cycle %0d actual %h required 000", cyc, obsVec());
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_after_reset cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_idle_gap(input int n);
    key_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_idle_gap cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_clean_press();
    int nStr = 0, firstEdge = -1;
    sw = 4'hA;
    for (int e = 0; e < 26; e++) begin
      key_n = 1'b0;
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_clean_press cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
      if (strobeA) begin nStr++; if (firstEdge < 0) firstEdge = e; end
    end
    checkCount++;
    if (firstEdge != 6) begin
      failCount++; $display("[TB] FAIL clean_press_edge actual %0d required 6", firstEdge);
    end
    checkCount++;
    if (nStr != 1) begin
      failCount++; $display("[TB] FAIL clean_press_count actual %0d required 1", nStr);
    end
    checkCount++;
    if (dataA !== 4'hA || pressedA !== 1'b1) begin
      failCount++; $display("[TB] FAIL clean_press_state actual data %h pressed %b required A 1", dataA, pressedA);
    end
    test_idle_gap(12);
  endtask

  task automatic test_press_bounce();
    int nStr = 0, firstEdge = -1;
    sw = 4'h6;
    for (int e = 0; e < 26; e++) begin
      key_n = (e == 3) ? 1'b1 : 1'b0;
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_press_bounce cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
      if (strobeA) begin nStr++; if (firstEdge < 0) firstEdge = e; end
    end
    checkCount++;
    if (firstEdge != 10 || nStr != 1) begin
      failCount++;
      $display("[TB] FAIL press_bounce actual edge %0d count %0d required edge 10 count 1", firstEdge, nStr);
    end
    test_idle_gap(12);
  endtask

  task automatic test_auto_repeat();
    int edgeQ[$];
    logic [3:0] dataQ[$];
    int expEdge[4] = '{6, 26, 34, 42};
    logic [3:0] expDat[4] = '{4'hA, 4'h3, 4'h3, 4'h3};
    int fallEdge = -1;
    logic prevPressed;
    for (int e = 0; e < 46; e++) begin
      key_n = 1'b0;
      sw = (e >= 15) ? 4'h3 : 4'hA;
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_auto_repeat cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
      if (strobeA) begin edgeQ.push_back(e); dataQ.push_back(dataA); end
    end
    checkCount++;
    if (edgeQ.size() != 4) begin
      failCount++; $display("[TB] FAIL repeat_count actual %0d required 4", edgeQ.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checkCount++;
        if (edgeQ[k] != expEdge[k] || dataQ[k] !== expDat[k]) begin
          failCount++;
          $display("[TB] FAIL repeat_strobe_%0d actual edge %0d data %h required edge %0d data %h",
                   k, edgeQ[k], dataQ[k], expEdge[k], expDat[k]);
        end
      end
    end
    for (int r = 0; r < 10; r++) begin
      prevPressed = pressedA;
      key_n = 1'b1;
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_repeat_release cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
      if (prevPressed && !pressedA) fallEdge = r;
    end
    checkCount++;
    if (fallEdge != 6) begin
      failCount++; $display("[TB] FAIL release_timing actual %0d required 6", fallEdge);
    end
    test_idle_gap(4);
  endtask

  task automatic test_release_bounce();
    int edgeQ[$];
    bit dropped = 0;
    sw = 4'h9;
    for (int e = 0; e < 37; e++) begin
      key_n = (e == 10 || e == 11) ? 1'b1 : 1'b0;
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_release_bounce cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
      if (strobeA) edgeQ.push_back(e);
      if (e >= 6 && !pressedA) dropped = 1;
    end
    checkCount++;
    if (dropped) begin
      failCount++; $display("[TB] FAIL release_bounce_pressed actual 0 required 1");
    end
    checkCount++;
    if (edgeQ.size() != 2 || edgeQ[0] != 6 || edgeQ[edgeQ.size()-1] != 34) begin
      failCount++;
      $display("[TB] FAIL release_bounce_strobes actual count %0d required strobes at 6 and 34", edgeQ.size());
    end
    test_idle_gap(12);
  endtask

  task automatic test_reset_while_held();
    int bad = 0, firstEdge = -1;
    sw = 4'hA;
    for (int e = 0; e < 42; e++) begin
      key_n = 1'b0;
      reset = (e == 10 || e == 11) ? 1'b1 : 1'b0;
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_reset_held cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
      if (e >= 10 && {strobeA, dataA, pressedA} !== 6'h00) bad++;
    end
    reset = 1'b0;
    checkCount++;
    if (bad != 0) begin
      failCount++; $display("[TB] FAIL reset_held_quiet actual %0d active cycles required 0", bad);
    end
    sw = 4'h5;
    test_idle_gap(5);
    for (int e = 0; e < 10; e++) begin
      key_n = 1'b0;
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_reset_repress cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
      if (strobeA && firstEdge < 0) firstEdge = e;
    end
    checkCount++;
    if (firstEdge != 6 || dataA !== 4'h5) begin
      failCount++;
      $display("[TB] FAIL reset_repress actual edge %0d data %h required edge 6 data 5", firstEdge, dataA);
    end
    test_idle_gap(12);
  endtask

  task automatic test_repeat_disabled();
    int nA = 0, nB = 0;
    sw = 4'hC;
    for (int e = 0; e < 100; e++) begin
      key_n = 1'b0;
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_repeat_off cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
      if (strobeA) nA++;
      if (strobeB) nB++;
    end
    checkCount++;
    if (nB != 1 || pressedB !== 1'b1) begin
      failCount++; $display("[TB] FAIL repeat_off_count actual %0d pressed %b required 1 1", nB, pressedB);
    end
    checkCount++;
    if (nA != 11) begin
      failCount++; $display("[TB] FAIL repeat_on_count actual %0d required 11", nA);
    end
    test_idle_gap(12);
  endtask

  task automatic test_back_to_back(input int n);
    int segLeft = 0;
    logic level = 1'b1;
    logic prevA = 1'b0, prevB = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (segLeft == 0) begin
        level = 1'($urandom_range(0, 1));
        segLeft = $urandom_range(1, 30);
      end
      segLeft--;
      key_n = level;
      sw = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0;
      tick();
      checkCount++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL model_random cycle %0d actual %h required %h", cyc, obsVec(), expVec());
      end
      if (strobeA || strobeB) begin
        checkCount++;
        if ((strobeA && prevA) || (strobeB && prevB)) begin
          failCount++;
          $display("[TB] FAIL back_to_back cycle %0d actual consecutive strobes required isolated", cyc);
        end
      end
      prevA = strobeA;
      prevB = strobeB;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_auto_repeat();
    test_release_bounce();
    test_reset_while_held();
    test_repeat_disabled();
    test_back_to_back(600);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/key_entry.md
# key_entry

Input-conditioning stage that sits directly upstream of the digit-capture block. It synchronises the raw push-button and the 4-bit switch bank, debounces the button, and emits a single-cycle `strobe` with a latched 4-bit `data` nibble for each accepted press. Optional auto-repeat produces further strobes while the button is held. The digit-capture block consumes `strobe`/`data` in place of a raw key edge.

## Interface
- `DEBOUNCE`, 500000: consecutive stable cycles needed to accept a press or a release (10 ms at 50 MHz); ≥1.
- `REPEAT_EN`, 1: 1 enables auto-repeat, 0 disables it.
- `REPEAT_DELAY`, 25000000: held cycles from the first strobe to the first repeat strobe; ≥1.
- `REPEAT_PERIOD`, 5000000: cycles between successive repeat strobes; ≥1.
- `CNT_W`, 25: counter width; every count parameter is < 2^CNT_W.

- `clock`  in  1  system clock (CLOCK50 domain).
- `reset`  in  1  synchronous, active-high reset.
- `key_n`  in  1  raw push-button, active-low, asynchronous.
- `sw`  in  4  raw switches, asynchronous.
- `strobe`  out  1  one-cycle pulse per accepted press or repeat.
- `data`  out  4  switch value captured with the most recent strobe.
- `pressed`  out  1  debounced button state, 1 = held.

## Operation
- Synchronisers: a two-flop chain on `key_n` gives `key_s`; a two-flop chain on each `sw` bit gives `sw_s`. On reset the `key_n` flops load 1 and the `sw` flops load 0.
- One shared counter `cnt` (CNT_W bits) is cleared on every state change.
- States:
  - ARM (reset state, pressed=0):
    - `key_s`=0 → clear `cnt`.
    - `key_s`=1 with `cnt`==DEBOUNCE-1 → IDLE.
    - Otherwise `cnt`++.
    - A button held through reset therefore never produces a strobe until it has been released for DEBOUNCE cycles.
  - IDLE: `key_s`=0 → PRESS_WAIT.
  - PRESS_WAIT:
    - `key_s`=1 (bounce) → IDLE.
    - `key_s`=0 with `cnt`==DEBOUNCE-1 → HELD, strobe.
    - Otherwise `cnt`++.
  - HELD:
    - `key_s`=1 → RELEASE_WAIT.
    - REPEAT_EN=1 and `cnt`==REPEAT_DELAY-1 → REPEAT, strobe.
    - Otherwise `cnt`++. With REPEAT_EN=0, `cnt` saturates and no repeat is ever issued.
  - REPEAT:
    - `key_s`=1 → RELEASE_WAIT.
    - `cnt`==REPEAT_PERIOD-1 → strobe, clear `cnt`, stay in REPEAT.
    - Otherwise `cnt`++.
  - RELEASE_WAIT:
    - `key_s`=0 (bounce) → HELD with `cnt` cleared, no strobe.
    - `key_s`=1 with `cnt`==DEBOUNCE-1 → IDLE.
    - Otherwise `cnt`++.
- Strobe rule: whenever a strobe is issued, `strobe` is registered high for exactly one cycle and `data` is loaded with `sw_s` on the same edge. `data` holds until the next strobe; switch changes between strobes are ignored.
- `pressed` = 1 in HELD, REPEAT and RELEASE_WAIT; 0 in ARM, IDLE and PRESS_WAIT. It is registered.
- Reset values: `strobe`=0, `data`=0, `pressed`=0, state=ARM, `cnt`=0.
- Reset mid-operation: on the reset edge all outputs take their reset values, including aborting a strobe in flight. Reset has priority over every transition.

## Timing
- Edge numbering: edge 0 is the first rising edge at which `key_n` is sampled low. Timelines below assume the block is idle (ARM already passed) and inputs are clean.
- Press path:
  - `key_s`=0 after edge 1.
  - PRESS_WAIT entered at edge 2.
  - HELD entered and `strobe` high in the cycle after edge DEBOUNCE+2.
  - `pressed` rises on the same edge as `strobe`.
- Repeat path:
  - First repeat strobe after edge DEBOUNCE+2+REPEAT_DELAY.
  - Subsequent repeat strobes every REPEAT_PERIOD edges after that.
- Release path:
  - `key_s` goes high 2 edges after `key_n` rises.
  - `pressed` falls DEBOUNCE+1 edges after that.
- Back-to-back: `strobe` is never high in two consecutive cycles for any parameter value ≥1.
- `data` is valid in the same cycle as `strobe` and stays stable while `strobe` is high.

## Test plan
All scenarios use DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 unless noted.

- Clean press: reset 3 cycles, key released 10 cycles, `sw`=4'hA, key low from edge 0 → single `strobe` after edge 6, `data`=A, `pressed`=1; stays 1 with no further strobe before edge 26.
- Press bounce: key low for 3 edges, high 1, then low and held → strobe only 6 edges after the final falling sample; exactly one strobe.
- Auto-repeat: hold key, change `sw` to 4'h3 at edge 15 → strobes after edges 6 (`data`=A), 26 (`data`=3), 34 and 42; release → `pressed` falls 5 edges after `key_s` rises.
- Release bounce: while held, key high 2 cycles then low → `pressed` stays 1, no strobe; the next repeat comes REPEAT_DELAY edges later.
- Reset while held: assert reset at edge 10 with key low, deassert, keep key low 30 cycles → `strobe`, `data`, `pressed` all 0 throughout. Then release 5 cycles and press → normal strobe after DEBOUNCE+2.
- REPEAT_EN=0: hold key 100 cycles → exactly one strobe.
